// File: rtl/trace_stream_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trace_stream_scheduler_if
// Description : Bundles every non-clock/reset signal of the trace stream
//               scheduler. This covers run control, the trace ROM bus,
//               the predictor handshake and the statistics.
//               master : the scheduler (drives ROM reads, predictor, stats)
//               slave  : the environment (ROMs, predictor, run control)
//   Run control : start, ch_mask, last_addr, quantum, switch_req
//                 cur_ch, busy, done
//   ROM bus     : mem_en, mem_addr -> ; <- mem_pc, mem_br
//   Predictor   : pred_valid, pred_pc, actual_branch -> ; <- pred_ready,
//                 res_valid, res_taken
//   Statistics  : total_cnt, correct_cnt, total_all, correct_all
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_stream_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int PC_W   = 32,
    parameter int Q_W    = 16,
    parameter int STAT_W = 32,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic                       start;
    logic [NUM_CH-1:0]          ch_mask;
    logic [NUM_CH*ADDR_W-1:0]   last_addr;
    logic [Q_W-1:0]             quantum;
    logic                       switch_req;
    logic [NUM_CH-1:0]          mem_en;
    logic [NUM_CH*ADDR_W-1:0]   mem_addr;
    logic [NUM_CH*PC_W-1:0]     mem_pc;
    logic [NUM_CH-1:0]          mem_br;
    logic                       pred_valid;
    logic                       pred_ready;
    logic [PC_W-1:0]            pred_pc;
    logic                       actual_branch;
    logic                       res_valid;
    logic                       res_taken;
    logic [CH_W-1:0]            cur_ch;
    logic                       busy;
    logic                       done;
    logic [NUM_CH*STAT_W-1:0]   total_cnt;
    logic [NUM_CH*STAT_W-1:0]   correct_cnt;
    logic [STAT_W-1:0]          total_all;
    logic [STAT_W-1:0]          correct_all;

    modport master (
        input  start, ch_mask, last_addr, quantum, switch_req,
        input  mem_pc, mem_br, pred_ready, res_valid, res_taken,
        output mem_en, mem_addr, pred_valid, pred_pc, actual_branch,
        output cur_ch, busy, done, total_cnt, correct_cnt, total_all, correct_all
    );

    modport slave (
        output start, ch_mask, last_addr, quantum, switch_req,
        output mem_pc, mem_br, pred_ready, res_valid, res_taken,
        input  mem_en, mem_addr, pred_valid, pred_pc, actual_branch,
        input  cur_ch, busy, done, total_cnt, correct_cnt, total_all, correct_all
    );
endinterface
`default_nettype wire

// File: rtl/trace_stream_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trace_stream_scheduler
// Description : Reads per-channel branch traces (PC + outcome) from 1-cycle
//               latency ROMs and time-multiplexes them round-robin into one
//               branch predictor. Each channel gets a programmable quantum
//               of branches per turn. An external switch request can force
//               a turn to end early. Per-channel and aggregate total/correct
//               counters saturate at all-ones.
// Ports       : clk, reset (async, active-high)
//               bus (master modport of trace_stream_scheduler_if)
// Revision    : 1.0 - initial release
// ============================================================================
module trace_stream_scheduler #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int PC_W   = 32,
    parameter int Q_W    = 16,
    parameter int STAT_W = 32,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      reset,
    trace_stream_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [Q_W-1:0]    c_q_one      = Q_W'(1);
    localparam logic [Q_W:0]      c_q_one_wide = (Q_W+1)'(1);
    localparam logic [NUM_CH-1:0] c_ch_one     = NUM_CH'(1);
    localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);
    localparam logic [STAT_W-1:0] c_stat_one   = STAT_W'(1);

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [NUM_CH-1:0]              r_active;
    logic [NUM_CH-1:0][ADDR_W-1:0]  r_last;
    logic [NUM_CH-1:0][ADDR_W-1:0]  r_addr;
    logic [Q_W-1:0]                 r_quantum;
    logic [Q_W-1:0]                 r_qcnt;
    logic [CH_W-1:0]                r_cur;
    logic                           r_pend;
    logic [PC_W-1:0]                r_pred_pc;
    logic                           r_actual;
    logic [NUM_CH-1:0][STAT_W-1:0]  r_total;
    logic [NUM_CH-1:0][STAT_W-1:0]  r_correct;
    logic [STAT_W-1:0]              r_total_all;
    logic [STAT_W-1:0]              r_correct_all;

    logic [NUM_CH-1:0][PC_W-1:0]    w_mem_pc;
    logic                           w_start_ok;
    logic                           w_busy;
    logic                           w_retire;
    logic                           w_hit;
    logic [NUM_CH-1:0]              w_cur_onehot;
    logic                           w_last_hit;
    logic                           w_q_expired;
    logic                           w_switch;
    logic [NUM_CH-1:0]              w_active_nxt;
    logic [CH_W-1:0]                w_first_ch;
    logic [CH_W-1:0]                w_next_ch;
    logic [CH_W-1:0]                w_idx;
    logic                           w_found;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + c_stat_one;
    endfunction

    assign w_mem_pc     = bus.mem_pc;
    assign w_start_ok   = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    assign w_busy       = (r_state == S_READ) || (r_state == S_CAPTURE) ||
                          (r_state == S_ISSUE) || (r_state == S_WAIT);
    // res_valid only counts once the branch has been accepted; a result
    // strobe while still presenting is a protocol error and is dropped.
    assign w_retire     = (r_state == S_WAIT) && bus.res_valid;
    assign w_hit        = (bus.res_taken == r_actual);
    assign w_cur_onehot = c_ch_one << r_cur;
    assign w_last_hit   = (r_addr[r_cur] == r_last[r_cur]);
    // r_quantum already holds max(quantum,1); compare q_cnt+1 without overflow.
    assign w_q_expired  = (({1'b0, r_qcnt} + c_q_one_wide) >= {1'b0, r_quantum});
    // A switch request arriving in the retire cycle itself also takes effect.
    assign w_switch     = w_last_hit || w_q_expired || r_pend || bus.switch_req;
    assign w_active_nxt = w_last_hit ? (r_active & ~w_cur_onehot) : r_active;

    // Lowest participating channel of the mask presented with start.
    always_comb begin
        w_first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_mask[i]) begin
                w_first_ch = CH_W'(i);
            end
        end
    end

    // Next active channel after r_cur with wrap-around; the last candidate
    // examined is r_cur itself, so a lone remaining channel re-selects itself.
    always_comb begin
        w_next_ch = r_cur;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = CH_W'((int'(r_cur) + i) % NUM_CH);
            if (!w_found && w_active_nxt[w_idx]) begin
                w_next_ch = w_idx;
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.ch_mask == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:    w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (bus.pred_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.res_valid) begin
                    w_state_nxt = (w_active_nxt == '0) ? S_DONE : S_READ;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active      <= '0;
            r_last        <= '0;
            r_addr        <= '0;
            r_quantum     <= '0;
            r_qcnt        <= '0;
            r_cur         <= '0;
            r_pend        <= 1'b0;
            r_pred_pc     <= '0;
            r_actual      <= 1'b0;
            r_total       <= '0;
            r_correct     <= '0;
            r_total_all   <= '0;
            r_correct_all <= '0;
        end else if (w_start_ok) begin
            r_active      <= bus.ch_mask;
            r_last        <= bus.last_addr;
            r_quantum     <= (bus.quantum == '0) ? c_q_one : bus.quantum;
            r_addr        <= '0;
            r_qcnt        <= '0;
            r_cur         <= w_first_ch;
            r_pend        <= 1'b0;
            r_total       <= '0;
            r_correct     <= '0;
            r_total_all   <= '0;
            r_correct_all <= '0;
        end else begin
            if (w_busy && bus.switch_req) begin
                r_pend <= 1'b1;
            end
            if (r_state == S_CAPTURE) begin
                r_pred_pc <= w_mem_pc[r_cur];
                r_actual  <= bus.mem_br[r_cur];
            end
            if (w_retire) begin
                r_total[r_cur] <= sat_inc(r_total[r_cur]);
                r_total_all    <= sat_inc(r_total_all);
                if (w_hit) begin
                    r_correct[r_cur] <= sat_inc(r_correct[r_cur]);
                    r_correct_all    <= sat_inc(r_correct_all);
                end
                // The final address is never stepped past; the channel
                // simply drops out of the rotation instead.
                if (w_last_hit) begin
                    r_active <= w_active_nxt;
                end else begin
                    r_addr[r_cur] <= r_addr[r_cur] + c_addr_one;
                end
                if (w_switch) begin
                    r_qcnt <= '0;
                    r_cur  <= w_next_ch;
                    r_pend <= 1'b0;
                end else begin
                    r_qcnt <= r_qcnt + c_q_one;
                end
            end
        end
    end

    assign bus.mem_en        = (r_state == S_READ) ? w_cur_onehot : '0;
    assign bus.mem_addr      = r_addr;
    assign bus.pred_valid    = (r_state == S_ISSUE);
    assign bus.pred_pc       = r_pred_pc;
    assign bus.actual_branch = r_actual;
    assign bus.cur_ch        = r_cur;
    assign bus.busy          = w_busy;
    assign bus.done          = (r_state == S_DONE);
    assign bus.total_cnt     = r_total;
    assign bus.correct_cnt   = r_correct;
    assign bus.total_all     = r_total_all;
    assign bus.correct_all   = r_correct_all;

endmodule
`default_nettype wire

// File: tb/tb_trace_stream_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_trace_stream_scheduler
// Description : Directed self-checking bench for trace_stream_scheduler.
//               Models the per-channel trace ROMs and serves the predictor
//               handshake from tasks. Statistics are 4 bits wide so that
//               saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_stream_scheduler;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 16;
    localparam int PC_W   = 32;
    localparam int Q_W    = 16;
    localparam int STAT_W = 4;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    trace_stream_scheduler_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PC_W(PC_W),
                                .Q_W(Q_W), .STAT_W(STAT_W), .CH_W(CH_W)) bus();

    trace_stream_scheduler #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PC_W(PC_W),
                             .Q_W(Q_W), .STAT_W(STAT_W), .CH_W(CH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [PC_W-1:0] rom_pc(input int c, input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 + (PC_W'(c) << 20) + PC_W'({a, 2'b00});
    endfunction

    function automatic logic rom_br(input int c, input logic [ADDR_W-1:0] a);
        logic [31:0] cv;
        cv = c;
        return a[0] ^ a[1] ^ cv[0];
    endfunction

    // Single-port trace ROMs: data appears one cycle after the read enable.
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.mem_en[c]) begin
                bus.mem_pc[c*PC_W +: PC_W] <= rom_pc(c, bus.mem_addr[c*ADDR_W +: ADDR_W]);
                bus.mem_br[c]              <= rom_br(c, bus.mem_addr[c*ADDR_W +: ADDR_W]);
            end
        end
    end

    task automatic start_run(input logic [NUM_CH-1:0] mask,
                             input logic [NUM_CH*ADDR_W-1:0] last,
                             input logic [Q_W-1:0] q);
        bus.ch_mask   = mask;
        bus.last_addr = last;
        bus.quantum   = q;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Serves one branch: expects a ROM read of (exp_ch, exp_addr), holds
    // pred_ready low for 'stall' cycles, then returns a result.
    task automatic serve_branch(input string tag, input int exp_ch, input int exp_addr,
                                input int stall, input bit invert, input bit inject,
                                input bit pulse_sw, input bit stop_in_wait);
        logic [NUM_CH-1:0] exp_en;
        logic [PC_W-1:0]   exp_pc;
        logic              exp_br;
        int                n;
        exp_en = '0;
        exp_en[exp_ch] = 1'b1;
        exp_pc = rom_pc(exp_ch, ADDR_W'(exp_addr));
        exp_br = rom_br(exp_ch, ADDR_W'(exp_addr));
        n = 0;
        while (bus.mem_en == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.mem_en !== exp_en || bus.cur_ch !== CH_W'(exp_ch) ||
            bus.mem_addr[exp_ch*ADDR_W +: ADDR_W] !== ADDR_W'(exp_addr)) begin
            failures++;
            $display("FAIL %s read: mem_en=%b cur_ch=%0d addr=%0d required mem_en=%b cur_ch=%0d addr=%0d",
                     tag, bus.mem_en, bus.cur_ch, bus.mem_addr[exp_ch*ADDR_W +: ADDR_W],
                     exp_en, exp_ch, exp_addr);
            return;
        end
        n = 0;
        while (bus.pred_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < stall; k++) begin
            checks++;
            if (bus.pred_valid !== 1'b1 || bus.pred_pc !== exp_pc || bus.actual_branch !== exp_br) begin
                failures++;
                $display("FAIL %s stall%0d: valid=%b pc=%h br=%b required valid=1 pc=%h br=%b",
                         tag, k, bus.pred_valid, bus.pred_pc, bus.actual_branch, exp_pc, exp_br);
            end
            bus.res_valid = inject && (k == 1);
            bus.res_taken = exp_br;
            if (inject && (k == 2)) begin
                bus.ch_mask = 4'b1111;
                bus.start   = 1'b1;
            end else begin
                bus.start   = 1'b0;
            end
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (bus.pred_valid !== 1'b1 || bus.pred_pc !== exp_pc || bus.actual_branch !== exp_br) begin
            failures++;
            $display("FAIL %s issue: valid=%b pc=%h br=%b required valid=1 pc=%h br=%b",
                     tag, bus.pred_valid, bus.pred_pc, bus.actual_branch, exp_pc, exp_br);
        end
        bus.pred_ready = 1'b1;
        bus.switch_req = pulse_sw;
        @(negedge clk);
        bus.pred_ready = 1'b0;
        bus.switch_req = 1'b0;
        checks++;
        if (bus.pred_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s wait: valid=%b busy=%b required valid=0 busy=1",
                     tag, bus.pred_valid, bus.busy);
        end
        if (stop_in_wait) begin
            return;
        end
        bus.res_valid = 1'b1;
        bus.res_taken = invert ? ~exp_br : exp_br;
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_en !== '0 || bus.pred_valid !== 1'b0 ||
            bus.cur_ch !== '0 || bus.total_all !== '0 || bus.mem_addr !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b mem_en=%b valid=%b cur=%0d tot=%0d addr=%h required all 0",
                     bus.busy, bus.done, bus.mem_en, bus.pred_valid, bus.cur_ch, bus.total_all, bus.mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty_mask();
        start_run(4'b0000, {4{16'd3}}, 16'd2);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.mem_en !== '0) begin
            failures++;
            $display("FAIL empty_mask: done=%b busy=%b mem_en=%b required done=1 busy=0 mem_en=0",
                     bus.done, bus.busy, bus.mem_en);
        end
    endtask

    task automatic test_round_robin();
        int chs[8]   = '{0, 0, 2, 2, 0, 0, 2, 2};
        int addrs[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        start_run(4'b0101, {4{16'd3}}, 16'd2);
        for (int i = 0; i < 8; i++) begin
            serve_branch("rr", chs[i], addrs[i], 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_done: done=%b busy=%b required done=1 busy=0", bus.done, bus.busy);
        end
        checks++;
        if (bus.total_cnt !== 16'h0404 || bus.correct_cnt !== 16'h0404) begin
            failures++;
            $display("FAIL rr_per_ch: total=%h correct=%h required total=0404 correct=0404",
                     bus.total_cnt, bus.correct_cnt);
        end
        checks++;
        if (bus.total_all !== 4'd8 || bus.correct_all !== 4'd8) begin
            failures++;
            $display("FAIL rr_all: total_all=%0d correct_all=%0d required 8 8",
                     bus.total_all, bus.correct_all);
        end
    endtask

    task automatic test_quantum_zero();
        start_run(4'b1111, {4{16'd0}}, 16'd0);
        for (int c = 0; c < 4; c++) begin
            serve_branch("q0", c, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.total_cnt !== 16'h1111 || bus.total_all !== 4'd4) begin
            failures++;
            $display("FAIL q0: done=%b total=%h total_all=%0d required done=1 total=1111 total_all=4",
                     bus.done, bus.total_cnt, bus.total_all);
        end
    endtask

    task automatic test_stall();
        start_run(4'b0010, {16'd0, 16'd0, 16'd1, 16'd0}, 16'd0);
        // Stalled issue with an early res_valid and a start pulse mid-run,
        // both of which must be ignored; the real result is mispredicted.
        serve_branch("stall", 1, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.total_cnt !== 16'h0010 || bus.correct_cnt !== 16'h0000 ||
            bus.total_all !== 4'd1 || bus.correct_all !== 4'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_stats: total=%h correct=%h all=%0d/%0d busy=%b required 0010 0000 1/0 busy=1",
                     bus.total_cnt, bus.correct_cnt, bus.total_all, bus.correct_all, bus.busy);
        end
        serve_branch("stall2", 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.total_cnt !== 16'h0020 || bus.correct_cnt !== 16'h0010 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL stall_end: total=%h correct=%h done=%b required 0020 0010 done=1",
                     bus.total_cnt, bus.correct_cnt, bus.done);
        end
    endtask

    task automatic test_saturate();
        start_run(4'b0001, {16'd0, 16'd0, 16'd0, 16'd16}, 16'd0);
        for (int i = 0; i < 17; i++) begin
            serve_branch("sat", 0, i, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 13) begin
                checks++;
                if (bus.total_cnt !== 16'h000E) begin
                    failures++;
                    $display("FAIL sat_14: total=%h required 000e", bus.total_cnt);
                end
            end
        end
        checks++;
        if (bus.total_cnt !== 16'h000F || bus.correct_cnt !== 16'h000F ||
            bus.total_all !== 4'hF || bus.correct_all !== 4'hF || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL sat_end: total=%h correct=%h all=%h/%h done=%b required 000f 000f f/f done=1",
                     bus.total_cnt, bus.correct_cnt, bus.total_all, bus.correct_all, bus.done);
        end
    endtask

    // Leaves the run in progress on channel 1; test_reset_midrun continues it.
    task automatic test_switch_req();
        start_run(4'b0011, {16'd0, 16'd0, 16'd5, 16'd5}, 16'd100);
        serve_branch("sw", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        serve_branch("sw", 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        serve_branch("sw_pulse", 0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        serve_branch("sw_after", 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        serve_branch("sw_cleared", 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.total_cnt !== 16'h0023 || bus.total_all !== 4'd5) begin
            failures++;
            $display("FAIL sw_stats: total=%h total_all=%0d required 0023 5",
                     bus.total_cnt, bus.total_all);
        end
    endtask

    task automatic test_reset_midrun();
        serve_branch("mid", 1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pred_valid !== 1'b0 || bus.mem_en !== '0 ||
            bus.cur_ch !== '0 || bus.pred_pc !== '0 || bus.mem_addr !== '0) begin
            failures++;
            $display("FAIL mid_ctrl: busy=%b done=%b valid=%b en=%b cur=%0d pc=%h addr=%h required all 0",
                     bus.busy, bus.done, bus.pred_valid, bus.mem_en, bus.cur_ch, bus.pred_pc, bus.mem_addr);
        end
        checks++;
        if (bus.total_cnt !== '0 || bus.correct_cnt !== '0 || bus.total_all !== '0 || bus.correct_all !== '0) begin
            failures++;
            $display("FAIL mid_stats: total=%h correct=%h all=%0d/%0d required all 0",
                     bus.total_cnt, bus.correct_cnt, bus.total_all, bus.correct_all);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_run(4'b0001, {16'd0, 16'd0, 16'd0, 16'd7}, 16'd0);
        serve_branch("rerun", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.total_all !== 4'd1 || bus.total_cnt !== 16'h0001) begin
            failures++;
            $display("FAIL rerun: total_all=%0d total=%h required 1 0001", bus.total_all, bus.total_cnt);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.ch_mask    = '0;
        bus.last_addr  = '0;
        bus.quantum    = '0;
        bus.switch_req = 1'b0;
        bus.pred_ready = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        @(negedge clk);
        test_reset();
        test_empty_mask();
        test_round_robin();
        test_quantum_zero();
        test_stall();
        test_saturate();
        test_switch_req();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
